// File: rtl/y_trim.sv
// y_trim: vertical crop/decimation of an AXI-stream video frame.
// Rows outside the Y window are dropped, and within the window one row out of
// (y_sub+1) is kept. The last beat of every kept row is parked in a hold
// register until the stage knows whether that row ends a line (EOL) or the
// frame (EOF). The SOF/SOL/EOL/EOF markers are then regenerated for the
// reduced frame.
module y_trim #(
  parameter int DATA_WIDTH    = 64,
  parameter int ROW_CNT_WIDTH = 12
) (
  input  logic                     aclk,
  input  logic                     aclk_reset_n,
  input  logic                     aclk_y_crop_en,
  input  logic [ROW_CNT_WIDTH-1:0] aclk_y_start,
  input  logic [ROW_CNT_WIDTH-1:0] aclk_y_size,
  input  logic [3:0]               aclk_y_sub,
  output logic                     aclk_s_tready,
  input  logic                     aclk_s_tvalid,
  input  logic [3:0]               aclk_s_tuser,
  input  logic                     aclk_s_tlast,
  input  logic [DATA_WIDTH-1:0]    aclk_s_tdata,
  input  logic                     aclk_m_tready,
  output logic                     aclk_m_tvalid,
  output logic [3:0]               aclk_m_tuser,
  output logic                     aclk_m_tlast,
  output logic [DATA_WIDTH-1:0]    aclk_m_tdata
);

  localparam int RW = ROW_CNT_WIDTH;
  localparam int EW = ROW_CNT_WIDTH + 1;

  localparam logic [3:0] U_SOF = 4'b0001;
  localparam logic [3:0] U_EOF = 4'b0010;
  localparam logic [3:0] U_SOL = 4'b0100;
  localparam logic [3:0] U_EOL = 4'b1000;

  // Frame configuration, shadowed when the SOF beat is accepted
  logic          crop_reg;
  logic [RW-1:0] start_reg;
  logic [EW-1:0] end_reg;      // one past the last ROI row, no wrap
  logic [3:0]    sub_reg;

  // Frame progress
  logic          rdy_reg;
  logic [RW-1:0] row_reg;
  logic [3:0]    phase_reg;
  logic          first_reg;    // next accepted beat starts a row
  logic          done_reg;     // frame finished (or no SOF seen yet): drop everything
  logic          sofp_reg;     // no kept row has been started in this frame yet

  // Hold register for the last beat of the most recent kept row
  logic                  h_valid_reg;
  logic                  h_eof_reg;
  logic [3:0]            h_user_reg;
  logic [DATA_WIDTH-1:0] h_data_reg;

  // Output register
  logic                  m_valid_reg;
  logic [3:0]            m_user_reg;
  logic                  m_last_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;

  // Decode of the beat currently presented on the slave side
  logic          sof_in;
  logic          row_end;
  logic          eff_crop;
  logic [RW-1:0] eff_start;
  logic [EW-1:0] eff_end;
  logic [3:0]    eff_sub;
  logic [RW-1:0] cur_row;
  logic [3:0]    cur_phase;
  logic [3:0]    phase_next;
  logic          cur_done;
  logic          cur_first;
  logic          cur_sofp;
  logic          in_roi;
  logic          past_roi;
  logic          kept;
  logic [3:0]    start_marker;
  logic          flush;
  logic          flush_eof;
  logic          out_free;
  logic          accept;
  logic          do_flush;

  assign aclk_m_tvalid = m_valid_reg;
  assign aclk_m_tuser  = m_user_reg;
  assign aclk_m_tlast  = m_last_reg;
  assign aclk_m_tdata  = m_data_reg;

  // Classify the presented beat and decide whether the hold register must be released first
  always_comb begin
    sof_in     = aclk_s_tvalid && aclk_s_tuser[0];
    row_end    = aclk_s_tlast || aclk_s_tuser[3];
    eff_crop   = sof_in ? aclk_y_crop_en : crop_reg;
    eff_start  = sof_in ? (aclk_y_crop_en ? aclk_y_start : '0) : start_reg;
    eff_end    = sof_in ? ({1'b0, aclk_y_start} + {1'b0, aclk_y_size}) : end_reg;
    eff_sub    = sof_in ? aclk_y_sub : sub_reg;
    cur_row    = sof_in ? '0 : row_reg;
    cur_phase  = sof_in ? 4'd0 : phase_reg;
    cur_done   = sof_in ? 1'b0 : done_reg;
    cur_first  = sof_in || first_reg || aclk_s_tuser[2];
    cur_sofp   = sof_in || sofp_reg;
    in_roi     = !eff_crop || ((cur_row >= eff_start) && ({1'b0, cur_row} < eff_end));
    past_roi   = eff_crop && ({1'b0, cur_row} >= eff_end);
    kept       = !cur_done && in_roi && (cur_phase == 4'd0);
    // The decimation phase only advances once the ROI has been entered
    phase_next = cur_phase;
    if (cur_row >= eff_start) begin
      phase_next = (cur_phase >= eff_sub) ? 4'd0 : cur_phase + 4'd1;
    end
    start_marker = 4'b0000;
    if (cur_first) begin
      start_marker = cur_sofp ? U_SOF : U_SOL;
    end

    flush     = 1'b0;
    flush_eof = 1'b0;
    if (h_valid_reg && h_eof_reg) begin
      flush     = 1'b1;
      flush_eof = 1'b1;
    end else if (h_valid_reg && aclk_s_tvalid) begin
      if (aclk_s_tuser[0]) begin
        // New frame while the old one never saw EOF: close it here
        flush     = 1'b1;
        flush_eof = 1'b1;
      end else if (cur_first && kept) begin
        flush = 1'b1;
      end else if (cur_first && past_roi) begin
        flush     = 1'b1;
        flush_eof = 1'b1;
      end else if (!kept && aclk_s_tuser[1]) begin
        flush     = 1'b1;
        flush_eof = 1'b1;
      end
    end

    out_free      = !m_valid_reg || aclk_m_tready;
    aclk_s_tready = rdy_reg && out_free && !flush;
    accept        = aclk_s_tvalid && aclk_s_tready;
    do_flush      = flush && out_free;
  end

  // Configuration shadow plus row/phase/frame-state tracking
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      rdy_reg   <= 1'b0;
      crop_reg  <= 1'b0;
      start_reg <= '0;
      end_reg   <= '0;
      sub_reg   <= 4'd0;
      row_reg   <= '0;
      phase_reg <= 4'd0;
      first_reg <= 1'b1;
      done_reg  <= 1'b1;
      sofp_reg  <= 1'b0;
    end else begin
      rdy_reg <= 1'b1;
      if (accept) begin
        if (sof_in) begin
          crop_reg  <= aclk_y_crop_en;
          start_reg <= eff_start;
          end_reg   <= eff_end;
          sub_reg   <= aclk_y_sub;
        end
        done_reg <= cur_done;
        sofp_reg <= cur_sofp;
        if (kept && cur_first) begin
          sofp_reg <= 1'b0;
        end
        if (!kept && aclk_s_tuser[1]) begin
          done_reg <= 1'b1;
        end
        if (row_end) begin
          row_reg   <= cur_row + RW'(1);
          phase_reg <= phase_next;
          first_reg <= 1'b1;
        end else begin
          row_reg   <= cur_row;
          phase_reg <= cur_phase;
          first_reg <= 1'b0;
        end
      end
      if (do_flush && flush_eof) begin
        done_reg <= 1'b1;
      end
    end
  end

  // Park the closing beat of a kept row until its end marker is known
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      h_valid_reg <= 1'b0;
      h_eof_reg   <= 1'b0;
      h_user_reg  <= 4'd0;
      h_data_reg  <= '0;
    end else if (accept && kept && row_end) begin
      h_valid_reg <= 1'b1;
      h_eof_reg   <= aclk_s_tuser[1];
      h_user_reg  <= start_marker;
      h_data_reg  <= aclk_s_tdata;
    end else if (do_flush) begin
      h_valid_reg <= 1'b0;
      h_eof_reg   <= 1'b0;
    end
  end

  // Single output stage: released hold beat has priority over pass-through beats
  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      m_valid_reg <= 1'b0;
      m_user_reg  <= 4'd0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else if (do_flush) begin
      m_valid_reg <= 1'b1;
      m_user_reg  <= h_user_reg | (flush_eof ? U_EOF : U_EOL);
      m_last_reg  <= 1'b1;
      m_data_reg  <= h_data_reg;
    end else if (accept && kept && !row_end) begin
      m_valid_reg <= 1'b1;
      m_user_reg  <= start_marker;
      m_last_reg  <= 1'b0;
      m_data_reg  <= aclk_s_tdata;
    end else if (aclk_m_tready) begin
      m_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y_trim.sv
// Directed testbench for y_trim: drives whole frames and compares every output
// beat against a queue built from the hand-listed rows that each case keeps.
module tb_y_trim;

  logic        aclk = 1'b0;
  logic        aclk_reset_n;
  logic        aclk_y_crop_en;
  logic [11:0] aclk_y_start;
  logic [11:0] aclk_y_size;
  logic [3:0]  aclk_y_sub;
  logic        aclk_s_tready;
  logic        aclk_s_tvalid;
  logic [3:0]  aclk_s_tuser;
  logic        aclk_s_tlast;
  logic [63:0] aclk_s_tdata;
  logic        aclk_m_tready;
  logic        aclk_m_tvalid;
  logic [3:0]  aclk_m_tuser;
  logic        aclk_m_tlast;
  logic [63:0] aclk_m_tdata;

  y_trim #(.DATA_WIDTH(64), .ROW_CNT_WIDTH(12)) dut (
    .aclk           (aclk),
    .aclk_reset_n   (aclk_reset_n),
    .aclk_y_crop_en (aclk_y_crop_en),
    .aclk_y_start   (aclk_y_start),
    .aclk_y_size    (aclk_y_size),
    .aclk_y_sub     (aclk_y_sub),
    .aclk_s_tready  (aclk_s_tready),
    .aclk_s_tvalid  (aclk_s_tvalid),
    .aclk_s_tuser   (aclk_s_tuser),
    .aclk_s_tlast   (aclk_s_tlast),
    .aclk_s_tdata   (aclk_s_tdata),
    .aclk_m_tready  (aclk_m_tready),
    .aclk_m_tvalid  (aclk_m_tvalid),
    .aclk_m_tuser   (aclk_m_tuser),
    .aclk_m_tlast   (aclk_m_tlast),
    .aclk_m_tdata   (aclk_m_tdata)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic        l;
    logic [3:0]  u;
    logic [63:0] d;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec     = 0;
  int    n_err     = 0;
  int    extra_cnt = 0;
  bit    throttle  = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int tid, input int row, input int beat);
    return {8'(tid), 24'(row), 32'(beat)};
  endfunction

  task automatic set_cfg(input bit en, input int start, input int size, input int sub);
    aclk_y_crop_en = en;
    aclk_y_start   = 12'(start);
    aclk_y_size    = 12'(size);
    aclk_y_sub     = 4'(sub);
  endtask

  // Expected output: kept rows in order, SOF on the first, EOF on the last
  task automatic expect_frame(input int tid, input int rows[$], input int beats);
    beat_t e;
    for (int i = 0; i < rows.size(); i++) begin
      for (int b = 0; b < beats; b++) begin
        e.u = 4'b0000;
        if (b == 0)         e.u = e.u | ((i == 0) ? 4'b0001 : 4'b0100);
        if (b == beats - 1) e.u = e.u | ((i == rows.size() - 1) ? 4'b0010 : 4'b1000);
        e.l = (b == beats - 1);
        e.d = mk_data(tid, rows[i], b);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_beat(input logic [3:0] u, input logic l, input logic [63:0] d, output bit ok);
    int t;
    aclk_s_tvalid = 1'b1;
    aclk_s_tuser  = u;
    aclk_s_tlast  = l;
    aclk_s_tdata  = d;
    t  = 0;
    ok = 1'b0;
    while (t <= 200) begin
      @(negedge aclk);
      if (aclk_s_tready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    if (!ok) begin
      chk("s_tready_timeout", 128'(aclk_s_tready), 128'(1));
      aclk_s_tvalid = 1'b0;
      return;
    end
    @(posedge aclk);
    #1;
    aclk_s_tvalid = 1'b0;
  endtask

  // Upstream frame; abort_row stops before beat 3 of that row, scramble
  // rewrites the live config after row 0, no_eof omits the EOF marker
  task automatic send_frame(input int tid, input int nrows, input int beats,
                            input int abort_row, input bit scramble, input bit no_eof);
    logic [3:0] u;
    bit ok;
    for (int r = 0; r < nrows; r++) begin
      for (int b = 0; b < beats; b++) begin
        if (r == abort_row && b == 3) return;
        u = 4'b0000;
        if (b == 0)         u = u | ((r == 0) ? 4'b0001 : 4'b0100);
        if (b == beats - 1) u = u | ((r == nrows - 1 && !no_eof) ? 4'b0010 : 4'b1000);
        send_beat(u, b == beats - 1, mk_data(tid, r, b), ok);
        if (!ok) return;
      end
      if (scramble && r == 0) begin
        aclk_y_start = aclk_y_start + 12'd1;
        aclk_y_size  = 12'd0;
        aclk_y_sub   = 4'd3;
      end
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge aclk);
      t++;
    end
    repeat (10) @(posedge aclk);
    #1;
    chk({tag, "_left"}, 128'(exp_q.size()), 128'(0));
    chk({tag, "_extra"}, 128'(extra_cnt), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m"}, 128'({aclk_m_tvalid, aclk_m_tuser, aclk_m_tlast, aclk_m_tdata}), 128'(0));
    chk({tag, "_s_tready"}, 128'(aclk_s_tready), 128'(0));
  endtask

  // Downstream ready: optionally low on one cycle out of eight
  initial begin
    int cyc;
    cyc = 0;
    aclk_m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      cyc++;
      aclk_m_tready = throttle ? ((cyc % 8) != 0) : 1'b1;
    end
  end

  // Output monitor: scoreboard on every handshake, stability while stalled
  initial begin
    logic [68:0] cur;
    logic [68:0] stall_val;
    bit          stall_flag;
    beat_t       e;
    stall_flag = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge aclk);
      if (!aclk_reset_n) begin
        stall_flag = 1'b0;
        continue;
      end
      cur = {aclk_m_tlast, aclk_m_tuser, aclk_m_tdata};
      if (stall_flag) chk("stall_hold", 128'(cur), 128'(stall_val));
      stall_flag = aclk_m_tvalid && !aclk_m_tready;
      stall_val  = cur;
      if (aclk_m_tvalid && aclk_m_tready) begin
        if (exp_q.size() == 0) begin
          extra_cnt++;
          $display("unexpected beat user=%h last=%b data=%h", aclk_m_tuser, aclk_m_tlast, aclk_m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 128'(cur), 128'({e.l, e.u, e.d}));
          if (e.l) $display("row out: data=%h user=%b", aclk_m_tdata, aclk_m_tuser);
        end
      end
    end
  end

  initial begin
    aclk_reset_n  = 1'b0;
    aclk_s_tvalid = 1'b0;
    aclk_s_tuser  = 4'd0;
    aclk_s_tlast  = 1'b0;
    aclk_s_tdata  = '0;
    set_cfg(0, 0, 0, 0);
    #12;
    check_reset_outputs("reset0");
    @(posedge aclk);
    #1;
    aclk_reset_n = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("ready_after_reset", 128'(aclk_s_tready), 128'(1));
    @(posedge aclk);
    #1;

    // 1: pass-through, 4 rows x 32 beats
    set_cfg(0, 0, 0, 0);
    expect_frame(1, '{0, 1, 2, 3}, 32);
    send_frame(1, 4, 32, -1, 0, 0);
    drain("t1");

    // 2: rows 2..4 of 8
    set_cfg(1, 2, 3, 0);
    expect_frame(2, '{2, 3, 4}, 4);
    send_frame(2, 8, 4, -1, 0, 0);
    drain("t2");

    // 3: rows 1..6, every second row, config changed mid-frame
    set_cfg(1, 1, 6, 1);
    expect_frame(3, '{1, 3, 5}, 3);
    send_frame(3, 8, 3, -1, 1, 0);
    drain("t3");

    // 4: ROI runs past the frame, EOF comes from the input
    set_cfg(1, 6, 10, 0);
    expect_frame(4, '{6, 7}, 2);
    send_frame(4, 8, 2, -1, 0, 0);
    drain("t4");

    // 5: back-pressure with single-beat rows, then with multi-beat rows
    throttle = 1'b1;
    set_cfg(1, 1, 3, 0);
    expect_frame(5, '{1, 2, 3}, 1);
    send_frame(5, 5, 1, -1, 0, 0);
    drain("t5a");
    set_cfg(0, 0, 0, 0);
    expect_frame(6, '{0, 1, 2}, 5);
    send_frame(6, 3, 5, -1, 0, 0);
    drain("t5b");
    throttle = 1'b0;

    // Missing upstream EOF: the next SOF closes the frame
    set_cfg(0, 0, 0, 0);
    expect_frame(7, '{0, 1}, 2);
    send_frame(7, 2, 2, -1, 0, 1);
    expect_frame(8, '{0, 1}, 2);
    send_frame(8, 2, 2, -1, 0, 0);
    drain("sof_closes");

    // Empty ROI: no output beats at all
    set_cfg(1, 3, 0, 0);
    send_frame(9, 5, 2, -1, 0, 0);
    drain("empty_roi");

    // 6: reset in the middle of row 2, then replay the frame
    set_cfg(1, 2, 3, 0);
    expect_frame(10, '{2, 3, 4}, 4);
    send_frame(10, 8, 4, 2, 0, 0);
    aclk_reset_n = 1'b0;
    #2;
    check_reset_outputs("reset_mid");
    exp_q.delete();
    repeat (3) @(posedge aclk);
    #1;
    check_reset_outputs("reset_hold");
    aclk_reset_n = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("ready_after_reset2", 128'(aclk_s_tready), 128'(1));
    chk("idle_after_reset2", 128'(aclk_m_tvalid), 128'(0));
    @(posedge aclk);
    #1;
    expect_frame(11, '{2, 3, 4}, 4);
    send_frame(11, 8, 4, -1, 0, 0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
